// File: rtl/mem_axil_master.sv
// mem_axil_master: bridges a picorv32-style native memory port onto an
// AXI-lite master with a single outstanding transaction.
//
// Ports
//   clk, resetn           : clock and synchronous active-low reset
//   mem_valid/instr/addr/wdata/wstrb, mem_ready, mem_rdata
//                         : CPU-side request/response (wstrb == 0 is a read)
//   aw*/w*/b*             : AXI-lite write address, write data, write response
//   ar*/r*                : AXI-lite read address, read data
//   bus_err               : sticky response-timeout flag
//
// Optional feature: define AXIL_MASTER_TIMEOUT_EN to enable the response
// timeout. After TIMEOUT_CYCLES the transaction is abandoned, mem_ready is
// pulsed, reads return 32'hDEAD_BEEF and bus_err sets until reset. Without
// the macro the master waits on the slave indefinitely and bus_err is 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a CPU request
// WADDR | awvalid/wvalid presented, waiting for both handshakes
// WRESP | bready presented, waiting for bvalid
// RADDR | arvalid presented, waiting for arready
// RDATA | rready presented, waiting for rvalid
// DONE  | mem_ready pulse cycle; blocks relaunch of the same request

module mem_axil_master #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,

  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] awaddr,
  output logic [2:0]  awprot,
  output logic        wvalid,
  input  logic        wready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        bvalid,
  output logic        bready,

  output logic        arvalid,
  input  logic        arready,
  output logic [31:0] araddr,
  output logic [2:0]  arprot,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,

  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  state_t      state, state_d;
  logic        awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, mem_ready_d;
  logic [31:0] awaddr_d, wdata_d, araddr_d, mem_rdata_d;
  logic [3:0]  wstrb_d;
  logic [2:0]  arprot_d;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt, cnt_d;
  logic             bus_err_d;
`endif

  assign awprot = 3'b000;

  always_comb begin
    state_d     = state;
    awvalid_d   = awvalid;
    wvalid_d    = wvalid;
    bready_d    = bready;
    arvalid_d   = arvalid;
    rready_d    = rready;
    mem_ready_d = 1'b0;
    awaddr_d    = awaddr;
    wdata_d     = wdata;
    wstrb_d     = wstrb;
    araddr_d    = araddr;
    arprot_d    = arprot;
    mem_rdata_d = mem_rdata;
`ifdef AXIL_MASTER_TIMEOUT_EN
    bus_err_d   = bus_err;
    cnt_d       = '0;
`endif

    unique case (state)
      IDLE: begin
        if (mem_valid && !mem_ready) begin
          if (|mem_wstrb) begin
            awaddr_d  = mem_addr;
            wdata_d   = mem_wdata;
            wstrb_d   = mem_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WADDR;
          end else begin
            araddr_d  = mem_addr;
            arprot_d  = {mem_instr, 2'b00};
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end

      WADDR: begin
        if (awvalid && awready) awvalid_d = 1'b0;
        if (wvalid && wready)   wvalid_d  = 1'b0;
        // Each channel is complete once it has handshaken, now or earlier.
        if ((!awvalid || awready) && (!wvalid || wready)) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end
      end

      WRESP: begin
        if (bvalid && bready) begin
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end
      end

      RADDR: begin
        if (arvalid && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RDATA;
        end
      end

      RDATA: begin
        if (rvalid && rready) begin
          rready_d    = 1'b0;
          mem_rdata_d = rdata;
          mem_ready_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

`ifdef AXIL_MASTER_TIMEOUT_EN
    if (state != IDLE && state != DONE) begin
      // Saturate so a phase change landing on the limit still times out
      // in the following phase.
      cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      // A state change this cycle means a handshake completed; it wins.
      if (cnt == CNT_MAX && state_d == state) begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        mem_ready_d = 1'b1;
        bus_err_d   = 1'b1;
        if (state == RADDR || state == RDATA) mem_rdata_d = 32'hDEAD_BEEF;
        state_d     = DONE;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      mem_ready <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      araddr    <= '0;
      arprot    <= '0;
      mem_rdata <= '0;
    end else begin
      state     <= state_d;
      awvalid   <= awvalid_d;
      wvalid    <= wvalid_d;
      bready    <= bready_d;
      arvalid   <= arvalid_d;
      rready    <= rready_d;
      mem_ready <= mem_ready_d;
      awaddr    <= awaddr_d;
      wdata     <= wdata_d;
      wstrb     <= wstrb_d;
      araddr    <= araddr_d;
      arprot    <= arprot_d;
      mem_rdata <= mem_rdata_d;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      bus_err <= bus_err_d;
    end
  end
`else
  // Constant 0; the comparison only keeps TIMEOUT_CYCLES referenced.
  assign bus_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mem_axil_master.sv
module tb_mem_axil_master;

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, bus_err;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [2:0]  awprot, arprot;

  always #5 clk = ~clk;

  mem_axil_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .bus_err(bus_err)
  );

  // Slave: mode 0 = scripted by the test, 1 = always ready, 2 = team RAM.
  int          mode = 1;
  logic [31:0] fast_rdata = '0;
  logic        scr_awready = 0, scr_wready = 0, scr_bvalid = 0;
  logic        scr_arready = 0, scr_rvalid = 0;
  logic        sl_awready = 0, sl_wready = 0, sl_bvalid = 0;
  logic        sl_arready = 0, sl_rvalid = 0;
  logic [31:0] sl_rdata = '0;

  assign awready = (mode == 1) ? 1'b1 : (mode == 0) ? scr_awready : sl_awready;
  assign wready  = (mode == 1) ? 1'b1 : (mode == 0) ? scr_wready  : sl_wready;
  assign bvalid  = (mode == 1) ? 1'b1 : (mode == 0) ? scr_bvalid  : sl_bvalid;
  assign arready = (mode == 1) ? 1'b1 : (mode == 0) ? scr_arready : sl_arready;
  assign rvalid  = (mode == 1) ? 1'b1 : (mode == 0) ? scr_rvalid  : sl_rvalid;
  assign rdata   = (mode == 1) ? fast_rdata : sl_rdata;

  logic [31:0] ram [0:255];
  logic        got_aw = 0, got_w = 0;
  logic [31:0] ram_waddr, ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bready, s_bvalid;
  logic        s_arvalid, s_arready, s_rready, s_rvalid;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [3:0]  s_wstrb;

  // Team RAM: registered 1-cycle ready pulses, read data one cycle after AR.
  always @(posedge clk) begin
    s_awvalid = awvalid; s_awready = awready; s_awaddr = awaddr;
    s_wvalid = wvalid; s_wready = wready; s_wdata = wdata; s_wstrb = wstrb;
    s_bready = bready; s_bvalid = bvalid;
    s_arvalid = arvalid; s_arready = arready; s_araddr = araddr;
    s_rready = rready; s_rvalid = rvalid;
    #1;
    if (mode == 2) begin
      if (s_awvalid && s_awready) begin got_aw = 1; ram_waddr = s_awaddr; end
      if (s_wvalid && s_wready) begin got_w = 1; ram_wdata = s_wdata; ram_wstrb = s_wstrb; end
      sl_awready = s_awvalid && !s_awready;
      sl_wready  = s_wvalid && !s_wready;
      if (s_bvalid && s_bready) sl_bvalid = 0;
      if (got_aw && got_w) begin
        for (int b = 0; b < 4; b++)
          if (ram_wstrb[b]) ram[ram_waddr[9:2]][8*b +: 8] = ram_wdata[8*b +: 8];
        got_aw = 0; got_w = 0; sl_bvalid = 1;
      end
      sl_arready = s_arvalid && !s_arready;
      if (s_rvalid && s_rready) sl_rvalid = 0;
      if (s_arvalid && s_arready) begin sl_rvalid = 1; sl_rdata = ram[s_araddr[9:2]]; end
    end
  end

  // Handshake monitor.
  int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, mr_cnt = 0;
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  logic [2:0]  last_arprot, last_awprot;

  always @(posedge clk) begin
    if (awvalid && awready) begin aw_cnt++; last_awaddr = awaddr; last_awprot = awprot; end
    if (wvalid && wready) begin w_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
    if (bvalid && bready) b_cnt++;
    if (arvalid && arready) begin ar_cnt++; last_araddr = araddr; last_arprot = arprot; end
    if (rvalid && rready) r_cnt++;
    if (mem_ready) mr_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after the sampling edge; lat = cycle (1-based) in which
  // mem_ready is first seen high.
  task automatic wait_ready(output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      lat++;
      if (mem_ready) break;
      @(posedge clk);
    end
    chk("req_done", {31'b0, mem_ready}, 32'd1);
  endtask

  // mem_valid stays high through the mem_ready cycle, as a CPU that samples
  // mem_ready on the following edge would leave it.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] strb, input logic instr, output int lat);
    @(negedge clk);
    mem_valid = 1; mem_addr = addr; mem_wdata = wd;
    mem_wstrb = wr ? strb : 4'b0000; mem_instr = instr;
    @(posedge clk);
    wait_ready(lat);
    @(posedge clk);
    #1 mem_valid = 0; mem_wstrb = 0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    logic        instr;
    logic [31:0] rd;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_prot;
  } vec_t;

  vec_t        vec [5];
  logic [31:0] ref_mem [0:15];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, a0, w0, b0, r0, m0, nwr, nrd;
    logic [31:0] last_rd;

    for (int i = 0; i < 256; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;

    vec[0] = '{1'b0, 32'h0001_0010, 32'h0, 4'h0, 1'b1, 32'h1234_5678, 32'h1234_5678, 3'b100};
    vec[1] = '{1'b1, 32'h0000_0040, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0, 32'h1234_5678, 3'b000};
    vec[2] = '{1'b0, 32'h0000_0080, 32'h0, 4'h0, 1'b0, 32'hFFFF_0000, 32'hFFFF_0000, 3'b000};
    vec[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'h8, 1'b1, 32'h0, 32'hFFFF_0000, 3'b000};
    vec[4] = '{1'b0, 32'h0000_0000, 32'h0, 4'h0, 1'b1, 32'h0000_0000, 32'h0000_0000, 3'b100};

    resetn = 0; mem_valid = 0; mem_instr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {26'b0, awvalid, wvalid, bready, arvalid, rready, mem_ready}, 32'd0);
    chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_wstrb", {28'b0, wstrb}, 32'd0);
    @(negedge clk) resetn = 1;

    // Always-ready slave, table-driven.
    mode = 1;
    for (int i = 0; i < 5; i++) begin
      fast_rdata = vec[i].rd;
      a0 = aw_cnt; w0 = w_cnt; r0 = ar_cnt; m0 = mr_cnt;
      do_req(vec[i].wr, vec[i].addr, vec[i].wd, vec[i].strb, vec[i].instr, lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd3);
      chk($sformatf("v%0d_mem_rdata", i), mem_rdata, vec[i].exp_rdata);
      chk($sformatf("v%0d_ready_pulses", i), mr_cnt - m0, 32'd1);
      if (vec[i].wr) begin
        chk($sformatf("v%0d_aw_count", i), aw_cnt - a0, 32'd1);
        chk($sformatf("v%0d_w_count", i), w_cnt - w0, 32'd1);
        chk($sformatf("v%0d_awaddr", i), last_awaddr, vec[i].addr);
        chk($sformatf("v%0d_wdata", i), last_wdata, vec[i].wd);
        chk($sformatf("v%0d_wstrb", i), {28'b0, last_wstrb}, {28'b0, vec[i].strb});
        chk($sformatf("v%0d_awprot", i), {29'b0, last_awprot}, 32'd0);
      end else begin
        chk($sformatf("v%0d_ar_count", i), ar_cnt - r0, 32'd1);
        chk($sformatf("v%0d_araddr", i), last_araddr, vec[i].addr);
        chk($sformatf("v%0d_arprot", i), {29'b0, last_arprot}, {29'b0, vec[i].exp_prot});
      end
    end

    // Write with W before AW, late bvalid.
    mode = 0;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; m0 = mr_cnt;
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h0000_0300; mem_wdata = 32'hAABB_CCDD; mem_wstrb = 4'b0101; mem_instr = 0;
    @(posedge clk); #1;
    chk("wr_both_valid", {30'b0, awvalid, wvalid}, 32'd3);
    scr_wready = 1;
    @(posedge clk); #1;
    scr_wready = 0;
    chk("wr_w_done_aw_held", {30'b0, awvalid, wvalid}, 32'd2);
    @(posedge clk); #1;
    scr_awready = 1;
    @(posedge clk); #1;
    scr_awready = 0;
    chk("wr_aw_done_bready", {30'b0, awvalid, bready}, 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("wr_no_early_ready", {31'b0, mem_ready}, 32'd0);
    end
    scr_bvalid = 1;
    @(posedge clk); #1;
    scr_bvalid = 0;
    chk("wr_ready_after_b", {30'b0, mem_ready, bready}, 32'd2);
    @(posedge clk); #1 mem_valid = 0; mem_wstrb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("wr_aw_count", aw_cnt - a0, 32'd1);
    chk("wr_w_count", w_cnt - w0, 32'd1);
    chk("wr_b_count", b_cnt - b0, 32'd1);
    chk("wr_ready_pulses", mr_cnt - m0, 32'd1);
    chk("wr_wstrb", {28'b0, last_wstrb}, 32'h5);
    chk("wr_wdata", last_wdata, 32'hAABB_CCDD);

    // Team RAM: write then read back, one transaction each.
    mode = 2;
    a0 = aw_cnt; r0 = ar_cnt;
    do_req(1'b1, 32'h0001_0000, 32'hCAFE_F00D, 4'hF, 1'b0, lat);
    ref_mem[0] = 32'hCAFE_F00D;
    chk("ram_wr_latency_le6", {31'b0, lat <= 6}, 32'd1);
    do_req(1'b0, 32'h0001_0000, 32'h0, 4'h0, 1'b0, lat);
    chk("ram_rd_latency_le6", {31'b0, lat <= 6}, 32'd1);
    chk("ram_readback", mem_rdata, 32'hCAFE_F00D);
    repeat (4) @(posedge clk);
    #1;
    chk("ram_one_aw", aw_cnt - a0, 32'd1);
    chk("ram_one_ar", ar_cnt - r0, 32'd1);

    // Randomised traffic against a byte-lane memory model.
    last_rd = 32'hCAFE_F00D;
    nwr = 0; nrd = 0;
    a0 = aw_cnt; r0 = ar_cnt;
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      int          idx;
      logic [31:0] d;
      logic [3:0]  s;
      wr  = ($urandom_range(0, 1) == 1);
      idx = $urandom_range(0, 15);
      d   = $urandom;
      s   = 4'($urandom_range(1, 15));
      do_req(wr, 32'h0001_0000 + 32'(idx * 4), d, s, 1'($urandom_range(0, 1)), lat);
      if (wr) begin
        nwr++;
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        nrd++;
        last_rd = ref_mem[idx];
      end
      chk($sformatf("rnd%0d_mem_rdata", i), mem_rdata, last_rd);
      chk($sformatf("rnd%0d_latency_le6", i), {31'b0, lat <= 6}, 32'd1);
    end
    chk("rnd_aw_total", aw_cnt - a0, nwr);
    chk("rnd_ar_total", ar_cnt - r0, nrd);

    // Reset while arvalid stalls, then a clean read on the first edge.
    mode = 0; scr_arready = 0;
    m0 = mr_cnt;
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h0000_0100; mem_wstrb = 0; mem_instr = 0;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("stall_arvalid_held", {31'b0, arvalid}, 32'd1);
    chk("stall_araddr", araddr, 32'h0000_0100);
    @(negedge clk);
    resetn = 0; mem_valid = 0;
    @(posedge clk); #1;
    chk("midrst_valids_low", {27'b0, awvalid, wvalid, arvalid, rready, mem_ready}, 32'd0);
    @(negedge clk);
    resetn = 1;
    mode = 1; fast_rdata = 32'h0BAD_F00D;
    mem_valid = 1; mem_addr = 32'h0000_0200;
    @(posedge clk);
    wait_ready(lat);
    chk("postrst_latency", lat, 32'd3);
    chk("postrst_rdata", mem_rdata, 32'h0BAD_F00D);
    @(posedge clk); #1 mem_valid = 0;
    chk("postrst_one_pulse", mr_cnt - m0, 32'd1);
    chk("bus_err_clear", {31'b0, bus_err}, 32'd0);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Read whose data never arrives.
    mode = 0; scr_arready = 1; scr_rvalid = 0;
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h0000_0400; mem_wstrb = 0;
    @(posedge clk);
    wait_ready(lat);
    chk("to_rd_latency", lat, 32'(TO + 2));
    chk("to_rd_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("to_rd_bus_err", {31'b0, bus_err}, 32'd1);
    @(posedge clk); #1 mem_valid = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("to_bus_err_sticky", {29'b0, bus_err, arvalid, rready}, 32'd4);
    @(negedge clk) resetn = 0;
    @(posedge clk); #1;
    chk("to_bus_err_reset", {31'b0, bus_err}, 32'd0);
    @(negedge clk) resetn = 1;

    // bvalid in the cycle the count reaches the limit.
    scr_arready = 0; scr_awready = 1; scr_wready = 1; scr_bvalid = 0;
    @(negedge clk);
    mem_valid = 1; mem_addr = 32'h0000_0500; mem_wdata = 32'h1111_2222; mem_wstrb = 4'hF;
    @(posedge clk);
    repeat (TO) @(posedge clk);
    #1 scr_bvalid = 1;
    @(posedge clk); #1;
    scr_bvalid = 0;
    chk("to_race_ready", {31'b0, mem_ready}, 32'd1);
    chk("to_race_no_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk); #1 mem_valid = 0; mem_wstrb = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
